// File: rtl/egress_cpl_gen_if.sv
// Bundle of request-side and TX-stream signals for the completion generator.
// The DUT connects through the slave modport; the upstream requester / TX core
// side uses the master modport.
interface egress_cpl_gen_if #(
  parameter int CPL_CNT_W = 16
);
  logic [15:0]          cpl_id;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_ur;
  logic [15:0]          req_rid;
  logic [7:0]           req_tag;
  logic [2:0]           req_tc;
  logic [1:0]           req_attr;
  logic [6:0]           req_laddr;
  logic [31:0]          req_data;
  logic                 m_axis_tx_tready;
  logic [63:0]          m_axis_tx_tdata;
  logic [7:0]           m_axis_tx_tkeep;
  logic                 m_axis_tx_sop;
  logic                 m_axis_tx_eop;
  logic                 m_axis_tx_tvalid;
  logic [3:0]           m_axis_tx_tuser;
  logic [CPL_CNT_W-1:0] cpl_cnt;

  modport slave (
    input  cpl_id, req_valid, req_ur, req_rid, req_tag, req_tc, req_attr,
           req_laddr, req_data, m_axis_tx_tready,
    output req_ready, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop,
           m_axis_tx_eop, m_axis_tx_tvalid, m_axis_tx_tuser, cpl_cnt
  );

  modport master (
    output cpl_id, req_valid, req_ur, req_rid, req_tag, req_tc, req_attr,
           req_laddr, req_data, m_axis_tx_tready,
    input  req_ready, m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_sop,
           m_axis_tx_eop, m_axis_tx_tvalid, m_axis_tx_tuser, cpl_cnt
  );
endinterface

// File: rtl/egress_cpl_gen.sv
// Single-DW read completion generator: turns an accepted register-read
// request into a two-beat 64-bit TLP (3DW header + optional data DW).
//
// state | meaning
// IDLE  | no packet in flight, request port open, tvalid low
// HDR   | header beat {DW1,DW0} presented with sop
// TAIL  | final beat {data|0,DW2} presented with eop; a new request may be
//       | accepted on the same cycle the tail is taken
module egress_cpl_gen #(
  parameter int CPL_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  egress_cpl_gen_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TAIL} state_t;

  state_t               state_q;
  logic                 tvalid_q;
  logic                 sop_q;
  logic                 eop_q;
  logic [63:0]          tdata_q;
  logic [7:0]           tkeep_q;
  logic [CPL_CNT_W-1:0] cnt_q;
  logic [CPL_CNT_W-1:0] cnt_d;

  // Holding register: only the fields still needed once the header beat
  // has been built at acceptance time.
  logic                 hold_ur_q;
  logic [15:0]          hold_rid_q;
  logic [7:0]           hold_tag_q;
  logic [6:0]           hold_laddr_q;
  logic [31:0]          hold_data_q;

  logic [63:0]          hdr_beat;
  logic [63:0]          tail_beat;
  logic [7:0]           tail_keep;
  logic [31:0]          dw2;

  function automatic logic [31:0] make_dw0(input logic ur, input logic [2:0] tc,
                                           input logic [1:0] attr);
    logic [31:0] dw;
    dw        = '0;
    dw[30:29] = ur ? 2'b00 : 2'b10;
    dw[28:24] = 5'b01010;
    dw[22:20] = tc;
    dw[13:12] = attr;
    dw[9:0]   = ur ? 10'd0 : 10'd1;
    return dw;
  endfunction

  function automatic logic [31:0] make_dw1(input logic [15:0] cid, input logic ur);
    return {cid, (ur ? 3'b001 : 3'b000), 1'b0, 12'd4};
  endfunction

  // Lower address is DW aligned for a single-DW completion.
  function automatic logic [31:0] make_dw2(input logic [15:0] rid, input logic [7:0] tag,
                                           input logic [6:0] laddr);
    return {rid, tag, 1'b0, laddr & 7'h7C};
  endfunction

  assign hdr_beat  = {make_dw1(bus.cpl_id, bus.req_ur),
                      make_dw0(bus.req_ur, bus.req_tc, bus.req_attr)};
  assign dw2       = make_dw2(hold_rid_q, hold_tag_q, hold_laddr_q);
  assign tail_beat = hold_ur_q ? {32'h0, dw2} : {hold_data_q, dw2};
  assign tail_keep = hold_ur_q ? 8'h0F : 8'hFF;
  assign cnt_d     = cnt_q + 1'b1;

  // Request port is open when idle, or when the tail is leaving this cycle.
  assign bus.req_ready = (state_q == S_IDLE) ||
                         ((state_q == S_TAIL) && bus.m_axis_tx_tready);

  assign bus.m_axis_tx_tdata  = tdata_q;
  assign bus.m_axis_tx_tkeep  = tkeep_q;
  assign bus.m_axis_tx_sop    = sop_q;
  assign bus.m_axis_tx_eop    = eop_q;
  assign bus.m_axis_tx_tvalid = tvalid_q;
  assign bus.m_axis_tx_tuser  = 4'b0000;
  assign bus.cpl_cnt          = cnt_q;

  // Packet sequencer with registered stream outputs and completion counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tvalid_q     <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      cnt_q        <= '0;
      hold_ur_q    <= 1'b0;
      hold_rid_q   <= '0;
      hold_tag_q   <= '0;
      hold_laddr_q <= '0;
      hold_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            hold_ur_q    <= bus.req_ur;
            hold_rid_q   <= bus.req_rid;
            hold_tag_q   <= bus.req_tag;
            hold_laddr_q <= bus.req_laddr;
            hold_data_q  <= bus.req_data;
            tdata_q      <= hdr_beat;
            tkeep_q      <= 8'hFF;
            sop_q        <= 1'b1;
            eop_q        <= 1'b0;
            tvalid_q     <= 1'b1;
            state_q      <= S_HDR;
          end
        end
        S_HDR: begin
          if (bus.m_axis_tx_tready) begin
            tdata_q <= tail_beat;
            tkeep_q <= tail_keep;
            sop_q   <= 1'b0;
            eop_q   <= 1'b1;
            state_q <= S_TAIL;
          end
        end
        S_TAIL: begin
          if (bus.m_axis_tx_tready) begin
            cnt_q <= cnt_d;
            if (bus.req_valid) begin
              hold_ur_q    <= bus.req_ur;
              hold_rid_q   <= bus.req_rid;
              hold_tag_q   <= bus.req_tag;
              hold_laddr_q <= bus.req_laddr;
              hold_data_q  <= bus.req_data;
              tdata_q      <= hdr_beat;
              tkeep_q      <= 8'hFF;
              sop_q        <= 1'b1;
              eop_q        <= 1'b0;
              state_q      <= S_HDR;
            end else begin
              tdata_q  <= '0;
              tkeep_q  <= '0;
              sop_q    <= 1'b0;
              eop_q    <= 1'b0;
              tvalid_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/egress_cpl_gen.md
EGRESS_CPL_GEN -- requirements
Module: egress_cpl_gen

Interface
REQ-001 SHALL have parameter CPL_CNT_W, default 16, width of the completion counter.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port cpl_id, input, 16, completer ID {bus,dev,func}, sampled at request acceptance.
REQ-005 SHALL have port req_valid, input, 1, read-completion request valid.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-007 SHALL have port req_ur, input, 1, 1 = unsupported request: emit Cpl (no data, status UR).
REQ-008 SHALL have port req_rid, input, 16, requester ID.
REQ-009 SHALL have port req_tag, input, 8, request tag.
REQ-010 SHALL have port req_tc, input, 3, traffic class.
REQ-011 SHALL have port req_attr, input, 2, attributes.
REQ-012 SHALL have port req_laddr, input, 7, lower address, with bits [1:0] forced to 0 in output.
REQ-013 SHALL have port req_data, input, 32, register read data for CplD.
REQ-014 SHALL have port m_axis_tx_tready, input, 1, core-side ready.
REQ-015 SHALL have ports m_axis_tx_tdata (output, 64), m_axis_tx_tkeep (output, 8), m_axis_tx_sop (output, 1), m_axis_tx_eop (output, 1), m_axis_tx_tvalid (output, 1), m_axis_tx_tuser (output, 4, always 0).
REQ-016 SHALL have port cpl_cnt, output, CPL_CNT_W, count of completions fully transmitted.

Function
REQ-017 SHALL implement FSM IDLE -> HDR -> TAIL; in IDLE, accept a request and go to HDR; in HDR, go to TAIL on tready; in TAIL, on tready go to IDLE, or to HDR if a request is accepted in that cycle.
REQ-018 SHALL drive req_ready = (state==IDLE) || (state==TAIL && m_axis_tx_tready), combinational.
REQ-019 SHALL register all request fields and cpl_id into a holding register on acceptance; inputs are don't-care afterwards.
REQ-020 SHALL latency: request accepted at cycle N -> tvalid=1, sop=1 at cycle N+1.
REQ-021 SHALL build header DW0: fmt[30:29]=2'b10 CplD / 2'b00 Cpl, type[28:24]=5'b01010, tc[22:20], td=ep=0, attr[13:12], length[9:0]=1 CplD / 0 Cpl, other bits 0.
REQ-022 SHALL build header DW1: cpl_id[31:16], status[15:13]=000 SC / 001 UR, bcm[12]=0, byte count[11:0]=4.
REQ-023 SHALL build header DW2: req_rid[31:16], req_tag[15:8], bit7=0, lower address[6:0].
REQ-024 SHALL send beat HDR: tdata={DW1,DW0}, tkeep=8'hFF, sop=1, eop=0.
REQ-025 SHALL send beat TAIL: CplD tdata={req_data,DW2}, tkeep=8'hFF; Cpl tdata={32'h0,DW2}, tkeep=8'h0F; sop=0, eop=1.
REQ-026 SHALL hold tdata/tkeep/sop/eop/tvalid stable while tvalid && !tready; tvalid never deasserts mid-packet.
REQ-027 SHALL keep tvalid=0 in IDLE; sustained throughput is one completion per 2 cycles with tready=1.
REQ-028 SHALL increment cpl_cnt by 1 on each TAIL beat handshake, wrapping modulo 2^CPL_CNT_W.

Reset
REQ-029 SHALL on rst assertion (including mid-packet) immediately set state=IDLE, tvalid=0, sop=0, eop=0, tdata=0, tkeep=0, tuser=0, cpl_cnt=0, and clear the holding register; the partial packet is abandoned, not completed.
REQ-030 SHALL make req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover a CplD test: cpl_id=16'h0100, rid=16'h0000, tag=8'h05, laddr=7'h28, data=32'hDEADBEEF, tready=1 -> beat0 tdata=64'h0100_0004_4A00_0001, beat1 tdata=64'hDEADBEEF_0000_0528, tkeep FF/FF, cpl_cnt=1.
REQ-032 SHALL cover a UR test: the same request with req_ur=1 -> beat0 tdata=64'h0100_2004_0A00_0000, beat1 tkeep=8'h0F, eop=1, no data DW.
REQ-033 SHALL cover backpressure: tready=0 for 5 cycles during HDR, then TAIL -> outputs held bit-stable, req_ready=0, exactly 2 beats delivered.
REQ-034 SHALL cover back-to-back: req_valid held high for 4 requests with tready=1 -> 8 beats in 8 consecutive cycles, cpl_cnt=4.
REQ-035 SHALL cover reset mid-packet: rst pulsed after the HDR handshake -> tvalid=0 asynchronously, no eop beat, next request produces a clean sop beat.
REQ-036 SHALL cover wrap: with CPL_CNT_W=4, 17 completions -> cpl_cnt=1.
